// File: rtl/tl_state_out.sv
`default_nettype none
// ============================================================================
// Module   : tl_state_out
// Purpose  : State register and light decoder for a two-street traffic light.
//            The upstream next-state logic proposes a state on {D1,D0}. It is
//            loaded only when the current state has dwelt long enough:
//              - green states leave no earlier than MIN_GRN cycles after entry
//              - yellow states leave exactly YEL_CYC cycles after entry
//            The block loads any proposed value. Sequencing legality is the
//            job of the next-state logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   YEL_CYC  cycles each yellow state is held                (1..15)
//   MIN_GRN  minimum cycles each green state is held         (1..15)
// Ports
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous active-high reset
//   D1, D0   in   1  proposed next state from the next-state logic
//   Q1, Q0   out  1  registered current state, fed back upstream
//   La       out  2  street-A light (00 green, 01 yellow, 10 red)
//   Lb       out  2  street-B light, same encoding
//   chg      out  1  one-cycle pulse in the cycle after each state change
// ============================================================================
module tl_state_out #(
    parameter int YEL_CYC = 4,
    parameter int MIN_GRN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       D1,
    input  logic       D0,
    output logic       Q1,
    output logic       Q0,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       chg
);

    // The state codes are fixed by the feedback contract with the
    // next-state logic, so the enum values are pinned explicitly.
    typedef enum logic [1:0] {
        A_GRN = 2'b00,
        A_YEL = 2'b01,
        B_GRN = 2'b10,
        B_YEL = 2'b11
    } state_t;

    localparam logic [1:0] LIGHT_GRN = 2'b00;
    localparam logic [1:0] LIGHT_YEL = 2'b01;
    localparam logic [1:0] LIGHT_RED = 2'b10;

    localparam logic [3:0] CNT_MAX  = 4'd15;
    // Last counter value of the mandatory dwell in each state class.
    localparam logic [3:0] GRN_LAST = 4'(MIN_GRN - 1);
    localparam logic [3:0] YEL_LAST = 4'(YEL_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       chg_nxt;
    logic       ld;
    logic [1:0] d_vec;

    assign d_vec = {D1, D0};

    // ------------------------------------------------------------------------
    // Load enable.
    // Green uses >= so that a green held past its minimum stays eligible. The
    // counter saturates at 15, and 15 >= any legal GRN_LAST, so the enable
    // never drops however long the green is held.
    // Yellow uses == so the exit happens at exactly YEL_CYC cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        ld = 1'b0;
        if (state[0] == 1'b0) begin
            ld = (cnt >= GRN_LAST);
        end else begin
            ld = (cnt == YEL_LAST);
        end
    end

    // ------------------------------------------------------------------------
    // Next state / next counter / change pulse.
    // D is only looked at when ld is high. A proposal equal to the current
    // state is not a change, so the counter keeps running.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
        chg_nxt   = 1'b0;
        if (ld && (d_vec != state)) begin
            state_nxt = state_t'(d_vec);
            cnt_nxt   = 4'd0;
            chg_nxt   = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State register. Reset is asynchronous, so an abort in the middle of a
    // yellow takes effect immediately rather than at the next edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= A_GRN;
            cnt   <= 4'd0;
            chg   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            chg   <= chg_nxt;
        end
    end

    assign Q1 = state[1];
    assign Q0 = state[0];

    // ------------------------------------------------------------------------
    // Light decode. It reads only the registered state, so there is no path
    // from D to the lamps.
    // ------------------------------------------------------------------------
    always_comb begin
        La = LIGHT_RED;
        Lb = LIGHT_RED;
        case (state)
            A_GRN: begin
                La = LIGHT_GRN;
                Lb = LIGHT_RED;
            end
            A_YEL: begin
                La = LIGHT_YEL;
                Lb = LIGHT_RED;
            end
            B_GRN: begin
                La = LIGHT_RED;
                Lb = LIGHT_GRN;
            end
            B_YEL: begin
                La = LIGHT_RED;
                Lb = LIGHT_YEL;
            end
            default: begin
                La = LIGHT_RED;
                Lb = LIGHT_RED;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_state_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_state_out
// Purpose  : Self-checking bench for tl_state_out. Instance "a" uses the
//            default parameters. Instance "b" uses YEL_CYC=1 and MIN_GRN=1.
//            A dwell-time reference model tracks each instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_state_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: YEL_CYC=4, MIN_GRN=2
    logic       rst_a, da1, da0, qa1, qa0, chg_a;
    logic [1:0] la_a, lb_a;
    // instance b: YEL_CYC=1, MIN_GRN=1
    logic       rst_b, db1, db0, qb1, qb0, chg_b;
    logic [1:0] la_b, lb_b;

    tl_state_out #(.YEL_CYC(4), .MIN_GRN(2)) dut_a (
        .clk(clk), .reset(rst_a), .D1(da1), .D0(da0),
        .Q1(qa1), .Q0(qa0), .La(la_a), .Lb(lb_a), .chg(chg_a)
    );

    tl_state_out #(.YEL_CYC(1), .MIN_GRN(1)) dut_b (
        .clk(clk), .reset(rst_b), .D1(db1), .D0(db0),
        .Q1(qb1), .Q0(qb0), .La(la_b), .Lb(lb_b), .chg(chg_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: current state, cycles since entry, change flag.
    logic [1:0] m_st_a, m_st_b;
    int         m_dw_a, m_dw_b;
    logic       m_ch_a, m_ch_b;

    function automatic logic [1:0] light_a(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] light_b(input logic [1:0] s);
        case (s)
            2'b10:   return 2'b00;
            2'b11:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [3:0] sat15(input int dw);
        return (dw > 15) ? 4'd15 : 4'(dw);
    endfunction

    // A green may leave once it has dwelt MIN_GRN cycles. A yellow leaves
    // only at exactly YEL_CYC cycles.
    task automatic model_step(input int yc, input int mg, input logic [1:0] d,
                              inout logic [1:0] st, inout int dw, inout logic ch);
        bit eligible;
        eligible = (st[0] == 1'b0) ? (dw + 1 >= mg) : (dw + 1 == yc);
        if (eligible && d != st) begin
            st = d;
            dw = 0;
            ch = 1'b1;
        end else begin
            dw = dw + 1;
            ch = 1'b0;
        end
    endtask

    task automatic model_reset_a();
        m_st_a = 2'b00; m_dw_a = 0; m_ch_a = 1'b0;
    endtask

    task automatic model_reset_b();
        m_st_b = 2'b00; m_dw_b = 0; m_ch_b = 1'b0;
    endtask

    // One clock edge: advance both models with the D values present at the
    // edge, then move 1 time unit past the edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (rst_a) model_reset_a();
        else model_step(4, 2, {da1, da0}, m_st_a, m_dw_a, m_ch_a);
        if (rst_b) model_reset_b();
        else model_step(1, 1, {db1, db0}, m_st_b, m_dw_b, m_ch_b);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        checks++;
        if ({qa1, qa0, la_a, lb_a, chg_a} !== 7'b00_00_10_0) begin
            errors++;
            $display("FAIL reset_hold: got Q=%b La=%b Lb=%b chg=%b, expected Q=00 La=00 Lb=10 chg=0",
                     {qa1, qa0}, la_a, lb_a, chg_a);
        end
        checks++;
        if (dut_a.cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", dut_a.cnt);
        end
        // Walk to state 11, then abort with reset in the middle of the cycle.
        rst_a = 1'b0;
        {da1, da0} = 2'b01; repeat (2) tick();
        {da1, da0} = 2'b10; repeat (4) tick();
        {da1, da0} = 2'b11; repeat (2) tick();
        checks++;
        if ({qa1, qa0} !== 2'b11) begin
            errors++;
            $display("FAIL reach_11: got Q=%b expected 11", {qa1, qa0});
        end
        #3;
        rst_a = 1'b1;
        model_reset_a();
        #1;
        checks++;
        if ({qa1, qa0, la_a, lb_a, chg_a} !== 7'b00_00_10_0) begin
            errors++;
            $display("FAIL async_reset: got Q=%b La=%b Lb=%b chg=%b, expected Q=00 La=00 Lb=10 chg=0",
                     {qa1, qa0}, la_a, lb_a, chg_a);
        end
        checks++;
        if (dut_a.cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_cnt: got %0d expected 0", dut_a.cnt);
        end
    endtask

    task automatic test_green_to_yellow();
        {da1, da0} = 2'b01;
        #1 rst_a = 1'b0;
        tick();
        checks++;
        if ({qa1, qa0, chg_a} !== 3'b00_0) begin
            errors++;
            $display("FAIL g2y_edge1: got Q=%b chg=%b expected Q=00 chg=0", {qa1, qa0}, chg_a);
        end
        tick();
        checks++;
        if ({qa1, qa0, chg_a, la_a, lb_a} !== 7'b01_1_01_10) begin
            errors++;
            $display("FAIL g2y_edge2: got Q=%b chg=%b La=%b Lb=%b expected Q=01 chg=1 La=01 Lb=10",
                     {qa1, qa0}, chg_a, la_a, lb_a);
        end
    endtask

    task automatic test_yellow_dwell();
        int n;
        n = 1;  // the entry cycle is already a yellow cycle
        {da1, da0} = 2'b10;
        tick();
        checks++;
        if (chg_a !== 1'b0) begin
            errors++;
            $display("FAIL yel_pulse_len: got chg=%b expected 0", chg_a);
        end
        for (int i = 0; i < 20; i++) begin
            if ({qa1, qa0} != 2'b01) break;
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL yel_dwell: got %0d cycles expected 4", n);
        end
        checks++;
        if ({qa1, qa0, chg_a, la_a, lb_a} !== 7'b10_1_10_00) begin
            errors++;
            $display("FAIL yel_exit: got Q=%b chg=%b La=%b Lb=%b expected Q=10 chg=1 La=10 Lb=00",
                     {qa1, qa0}, chg_a, la_a, lb_a);
        end
    endtask

    task automatic test_green_hold();
        {da1, da0} = 2'b10;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({qa1, qa0, chg_a} !== 3'b10_0) begin
                errors++;
                $display("FAIL hold_c%0d: got Q=%b chg=%b expected Q=10 chg=0", i, {qa1, qa0}, chg_a);
            end
        end
        checks++;
        if (dut_a.cnt !== 4'd15) begin
            errors++;
            $display("FAIL hold_sat: got cnt=%0d expected 15", dut_a.cnt);
        end
        {da1, da0} = 2'b11;
        tick();
        checks++;
        if ({qa1, qa0, chg_a} !== 3'b11_1) begin
            errors++;
            $display("FAIL hold_leave: got Q=%b chg=%b expected Q=11 chg=1", {qa1, qa0}, chg_a);
        end
    endtask

    task automatic test_glitch_and_loop();
        int pulses, changes;
        // yellow cycles 0..2: D glitches between non-zero codes, none loaded
        for (int c = 0; c < 3; c++) begin
            {da1, da0} = 2'($urandom_range(1, 3));
            tick();
            checks++;
            if ({qa1, qa0} !== 2'b11) begin
                errors++;
                $display("FAIL glitch_c%0d: got Q=%b expected 11", c, {qa1, qa0});
            end
        end
        {da1, da0} = 2'b00;
        tick();
        checks++;
        if ({qa1, qa0, chg_a} !== 3'b00_1) begin
            errors++;
            $display("FAIL glitch_load: got Q=%b chg=%b expected Q=00 chg=1", {qa1, qa0}, chg_a);
        end
        // Full cycle through all four states. Always propose the next state.
        pulses = 0;
        changes = 0;
        for (int i = 0; i < 60 && changes < 4; i++) begin
            {da1, da0} = m_st_a + 2'd1;
            tick();
            if (chg_a === 1'b1) pulses++;
            if (m_ch_a) changes++;
            checks++;
            if ({qa1, qa0} !== m_st_a) begin
                errors++;
                $display("FAIL loop_q_%0d: got %b expected %b", i, {qa1, qa0}, m_st_a);
            end
        end
        checks++;
        if (pulses != 4 || {qa1, qa0} !== 2'b00) begin
            errors++;
            $display("FAIL loop_pulses: got %0d pulses Q=%b expected 4 pulses Q=00", pulses, {qa1, qa0});
        end
    endtask

    task automatic test_param_corners();
        logic [1:0] expq;
        expq = 2'b00;
        #1 rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            {db1, db0} = expq + 2'd1;
            tick();
            expq = expq + 2'd1;
            checks++;
            if ({qb1, qb0, chg_b} !== {expq, 1'b1}) begin
                errors++;
                $display("FAIL corner_%0d: got Q=%b chg=%b expected Q=%b chg=1", i, {qb1, qb0}, chg_b, expq);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            {da1, da0} = 2'($urandom_range(0, 3));
            {db1, db0} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                rst_a = 1'b1; model_reset_a(); #2 rst_a = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) begin
                rst_b = 1'b1; model_reset_b(); #2 rst_b = 1'b0;
            end
            tick();
            checks++;
            if ({qa1, qa0, la_a, lb_a, chg_a} !== {m_st_a, light_a(m_st_a), light_b(m_st_a), m_ch_a}) begin
                errors++;
                $display("FAIL rand_a_%0d: got Q=%b La=%b Lb=%b chg=%b expected Q=%b La=%b Lb=%b chg=%b",
                         i, {qa1, qa0}, la_a, lb_a, chg_a,
                         m_st_a, light_a(m_st_a), light_b(m_st_a), m_ch_a);
            end
            checks++;
            if (dut_a.cnt !== sat15(m_dw_a)) begin
                errors++;
                $display("FAIL rand_cnt_a_%0d: got %0d expected %0d", i, dut_a.cnt, sat15(m_dw_a));
            end
            checks++;
            if ({qb1, qb0, la_b, lb_b, chg_b} !== {m_st_b, light_a(m_st_b), light_b(m_st_b), m_ch_b}) begin
                errors++;
                $display("FAIL rand_b_%0d: got Q=%b La=%b Lb=%b chg=%b expected Q=%b La=%b Lb=%b chg=%b",
                         i, {qb1, qb0}, la_b, lb_b, chg_b,
                         m_st_b, light_a(m_st_b), light_b(m_st_b), m_ch_b);
            end
            checks++;
            if (dut_b.cnt !== sat15(m_dw_b)) begin
                errors++;
                $display("FAIL rand_cnt_b_%0d: got %0d expected %0d", i, dut_b.cnt, sat15(m_dw_b));
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        {da1, da0} = 2'b00; {db1, db0} = 2'b00;
        model_reset_a(); model_reset_b();
        #12;
        test_reset();
        test_green_to_yellow();
        test_yellow_dwell();
        test_green_hold();
        test_glitch_and_loop();
        test_param_corners();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tl_state_out.md
TL_STATE_OUT -- requirements
Module: tl_state_out

Interface
REQ-001 Parameter: YEL_CYC, default 4, number of cycles each yellow state is held; legal range 1..15.
REQ-002 Parameter: MIN_GRN, default 2, minimum number of cycles each green state is held; legal range 1..15.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset. Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- D1  input  1  next-state bit 1 from the upstream next-state logic
- D0  input  1  next-state bit 0 from the upstream next-state logic
- Q1  output  1  current-state bit 1, fed back to the next-state logic
- Q0  output  1  current-state bit 0, fed back to the next-state logic
- La  output  2  street-A light: 2'b00 green, 2'b01 yellow, 2'b10 red
- Lb  output  2  street-B light, same encoding as La
- chg  output  1  one-cycle pulse on each state change

Function
REQ-004 State encoding {Q1,Q0}:
- 00: A green, B red
- 01: A yellow, B red
- 10: A red, B green
- 11: A red, B yellow
REQ-005 La and Lb SHALL be pure decodes of the registered {Q1,Q0}, with no input-to-output combinational path.
REQ-006 The block SHALL keep a 4-bit dwell counter cnt holding cycles spent in the current state, 0 on entry.
- cnt increments by 1 each cycle and saturates at 15.
REQ-007 Load enable ld:
- green states (Q0=0): ld=1 when cnt >= MIN_GRN-1.
- yellow states (Q0=1): ld=1 when cnt == YEL_CYC-1.
REQ-008 On a rising clk edge with ld=1 and {D1,D0} != {Q1,Q0}:
- {Q1,Q0} SHALL load {D1,D0}.
- cnt SHALL clear to 0.
- chg SHALL be 1 for exactly the following cycle.
REQ-009 On a rising clk edge with ld=0, or with {D1,D0} == {Q1,Q0}:
- {Q1,Q0} SHALL hold.
- cnt SHALL advance per REQ-006.
- chg SHALL be 0.
REQ-010 D1/D0 SHALL be sampled only at edges where ld=1; values while ld=0 have no effect.
REQ-011 The block SHALL load any {D1,D0} value without legality checks; transition legality is owned by the next-state logic.
REQ-012 With YEL_CYC=1, each yellow state SHALL last exactly 1 cycle.
REQ-013 With MIN_GRN=1, a green state SHALL be eligible to leave on its first cycle.
REQ-014 Saturation: in a green state held more than 15 cycles, cnt SHALL stay 15 and ld SHALL stay 1.
REQ-015 Green-to-yellow latency: {Q1,Q0} SHALL change 1 clk edge after the first cycle in which ld=1 and the D value differs.

Reset
REQ-016 While reset=1, regardless of clk:
- {Q1,Q0}=00, cnt=0, chg=0
- La=2'b00 (green), Lb=2'b10 (red)
REQ-017 Reset asserted mid-yellow or mid-count SHALL abort immediately to the REQ-016 values.
REQ-018 After reset deasserts, the first state load SHALL occur no earlier than the MIN_GRN-th rising edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios (defaults unless stated):
- Reset: assert reset mid-cycle with {Q1,Q0}=11 -> immediately Q=00, La=00, Lb=10, chg=0.
- A green to A yellow: D=01 held from reset release -> Q=01 at edge 2, chg=1 for one cycle, La=01.
- Yellow dwell: in state 01 with D=10 constant -> Q stays 01 for exactly 4 cycles, then becomes 10; La=10, Lb=00.
- Green hold with sensor active: state 10 with D=10 for 20 cycles -> no change, chg=0, cnt saturates at 15. Then D=11 -> Q=11 at the next edge.
- D glitch: D toggles during yellow cycles 0-2, D=00 at cycle 3 -> only 00 is loaded. Full loop 00→01→10→11→00 produces 4 chg pulses.
- Parameter corners: YEL_CYC=1, MIN_GRN=1 -> every state lasts 1 cycle under a changing D; no missed or double chg.
